// File: rtl/rl_ram_1r1w_reader_if.sv
// Burst stream carrying RAM words out of the reader: valid/ready handshake plus last-beat marker.
// master drives the beat, slave drives ready.
interface rl_ram_1r1w_reader_if #(
  parameter int DBITS = 32
);
  logic             valid;
  logic [DBITS-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/rl_ram_1r1w_reader.sv
// Burst reader: walks a 1-cycle-latency RAM from start_addr for len words into a 2-deep stream FIFO.
// First beat 3 cycles after start; reads throttle so buffered + in-flight words never exceed 2.
module rl_ram_1r1w_reader #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [ABITS-1:0] start_addr_i,
  input  logic [ABITS:0]   len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             re_o,
  output logic [ABITS-1:0] raddr_o,
  input  logic [DBITS-1:0] rdata_i,
  rl_ram_1r1w_reader_if.master m_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ABITS-1:0] raddr_q, raddr_d;
  logic [ABITS:0]   issue_left_q, issue_left_d;
  logic [ABITS:0]   beat_left_q, beat_left_d;
  logic             done_q, done_d;
  logic             inflight_q;
  logic [DBITS-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic             push_w, pop_w, re_w;
  logic [2:0]       occ_w;

  // A read issued last cycle lands in the FIFO now, so in-flight words count against the 2 slots.
  assign push_w = inflight_q;
  assign pop_w  = (count_q != 2'd0) && m_if.ready;
  assign occ_w  = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop_w};
  assign re_w   = (state_q == ISSUE) && (occ_w < 3'd2);

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d      = ISSUE;
            raddr_d      = start_addr_i;
            issue_left_d = len_i;
            beat_left_d  = len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (re_w) begin
          raddr_d      = raddr_q + 1'b1;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == {{ABITS{1'b0}}, 1'b1}) begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
      end
    endcase

    if ((state_q != IDLE) && pop_w) begin
      beat_left_d = beat_left_q - 1'b1;
      if (beat_left_q == {{ABITS{1'b0}}, 1'b1}) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      raddr_q      <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      done_q       <= 1'b0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      done_q       <= done_d;
      inflight_q   <= re_w;
      if (push_w) begin
        fifo_q[wr_ptr_q] <= rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_w) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_w} - {1'b0, pop_w};
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign re_o       = re_w;
  assign raddr_o    = raddr_q;
  assign m_if.valid = (count_q != 2'd0);
  assign m_if.data  = fifo_q[rd_ptr_q];
  assign m_if.last  = (count_q != 2'd0) && (beat_left_q == {{ABITS{1'b0}}, 1'b1});

endmodule

// File: doc/rl_ram_1r1w_reader.md
RL_RAM_1R1W_READER -- requirements
Module: rl_ram_1r1w_reader

Interface
REQ-001 Parameter ABITS, default 10, RAM address bits.
REQ-002 Parameter DBITS, default 32, RAM/stream data bits.
REQ-003 clk_i  in  1  single clock, rising edge; all state in this domain.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 start_i  in  1  start a burst read; sampled only while busy_o=0.
REQ-006 start_addr_i  in  ABITS  first word address, captured with start_i.
REQ-007 len_i  in  ABITS+1  words to read, captured with start_i; 0 = empty burst.
REQ-008 busy_o  out  1  burst in progress.
REQ-009 done_o  out  1  one-cycle pulse, burst complete.
REQ-010 re_o  out  1  RAM read issue strobe.
REQ-011 raddr_o  out  ABITS  RAM read address, valid while re_o=1.
REQ-012 rdata_i  in  DBITS  RAM read data, valid exactly one cycle after re_o/raddr_o.
REQ-013 m_valid_o  out  1  stream beat valid.
REQ-014 m_data_o  out  DBITS  stream beat data.
REQ-015 m_last_o  out  1  final beat of burst, qualified by m_valid_o.
REQ-016 m_ready_i  in  1  stream sink ready.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start_i with len_i>0; ISSUE->DRAIN after issuing the last read; DRAIN->IDLE on handshake of the beat with m_last_o=1.
REQ-018 start_i with len_i=0 in IDLE: no reads, no beats, done_o=1 next cycle, state stays IDLE, busy_o stays 0.
REQ-019 start_i while busy_o=1 is ignored.
REQ-020 busy_o=1 exactly while state is ISSUE or DRAIN.
REQ-021 Start sampled at end of cycle C: first re_o=1 in C+1 with raddr_o=start_addr_i.
REQ-022 Each subsequent issue increments raddr_o by 1 modulo 2**ABITS (2**ABITS-1 wraps to 0).
REQ-023 Exactly len words issued per burst; len=2**ABITS reads every word once; len>2**ABITS rereads wrapped addresses.
REQ-024 rdata_i captured into a 2-entry output FIFO the cycle after its issue, unconditionally; no handshake on RAM side.
REQ-025 Read issued in a cycle only if (FIFO occupancy + reads in flight − pop this cycle) < 2; data never lost or overwritten.
REQ-026 Output m_data_o/m_valid_o from FIFO head registers; first beat m_valid_o=1 in C+3.
REQ-027 With m_ready_i held 1, sustained throughput one beat per cycle; beats delivered in address order.
REQ-028 m_valid_o, m_data_o, m_last_o stable while m_valid_o=1 and m_ready_i=0.
REQ-029 m_last_o=1 only on beat number len of the burst.
REQ-030 done_o=1 in the cycle after the last-beat handshake; busy_o=0 in that same cycle; start_i accepted in that cycle.
REQ-031 m_ready_i with m_valid_o=0 has no effect.

Reset
REQ-032 rst_ni=0 at a clock edge: state IDLE, FIFO empty, in-flight read discarded, counters cleared.
REQ-033 Outputs during/after reset: busy_o=0, done_o=0, re_o=0, raddr_o=0, m_valid_o=0, m_last_o=0, m_data_o=0.
REQ-034 Reset mid-burst: no further beats or done_o for aborted burst; next start_i behaves as from power-up.

Verification
REQ-035 RAM preloaded mem[a]=a; start_addr=0x010, len=4, m_ready=1 -> re_o in C+1..C+4, beats 0x10..0x13 in C+3..C+6, m_last_o on 0x13, done_o in C+7.
REQ-036 start_addr=0x3FE, len=4 (ABITS=10) -> raddr_o 0x3FE,0x3FF,0x000,0x001; beats in same order.
REQ-037 len=8, m_ready_i toggled 1/0 each cycle and held 0 for 5 cycles mid-burst -> all 8 beats in order, none duplicated, data stable while stalled, at most 2 reads outstanding+buffered.
REQ-038 start_i with len=0 -> no re_o, no m_valid_o, done_o pulse next cycle; start_i during busy -> ignored, burst unaffected.
REQ-039 rst_ni=0 after 3rd beat of len=16 burst -> all outputs 0 next cycle; subsequent start_addr=0, len=2 yields beats 0x0,0x1 only.
REQ-040 len=1024 from 0x000 with random m_ready_i -> 1024 beats, scoreboard match, single done_o.
